// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC neuron sequencer.
package mac_pkg;

  localparam int unsigned D_MAX_DEF = 16;
  localparam int unsigned Q_MAX_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FETCH,
    S_ACC,
    S_RESULT,
    S_CLEAR,
    S_DONE
  } state_t;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Index counter with synchronous load-zero, increment-with-wrap and terminal-count flag.
module wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc_c
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_c  = (cnt_q == last);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc_c ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mac_sequencer.sv
// Runtime-configurable sequencer for the MAC neuron datapath: operand addressing,
// accumulator control and a valid/ready result handoff.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned D_MAX = D_MAX_DEF,
  parameter int unsigned Q_MAX = Q_MAX_DEF,
  localparam int unsigned DC_W = $clog2(D_MAX + 1),
  localparam int unsigned QC_W = $clog2(Q_MAX + 1),
  localparam int unsigned D_W  = cnt_w(D_MAX),
  localparam int unsigned Q_W  = cnt_w(Q_MAX),
  localparam int unsigned WA_W = cnt_w(D_MAX * Q_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DC_W-1:0] cfg_d,
  input  logic [QC_W-1:0] cfg_q,
  output logic [D_W-1:0]  x_addr,
  output logic [WA_W-1:0] w_addr,
  output logic            mem_rd,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [Q_W-1:0]  res_idx,
  output logic            busy,
  output logic            done
);

  state_t state_q, state_d;

  logic [DC_W-1:0] d_q, d_d, cfg_d_cl;
  logic [QC_W-1:0] q_q, q_d, cfg_q_cl;
  logic [WA_W-1:0] w_ptr_q, w_ptr_d;

  logic           term_clr, term_inc, term_tc_c;
  logic           nrn_clr, nrn_inc, nrn_tc_c;
  logic [D_W-1:0] term;
  logic [Q_W-1:0] neuron;

  logic mem_rd_q, mem_rd_d;
  logic acc_en_q, acc_en_d;
  logic acc_clr_q, acc_clr_d;
  logic res_valid_q, res_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign cfg_d_cl = (32'(cfg_d) > D_MAX) ? DC_W'(D_MAX) : cfg_d;
  assign cfg_q_cl = (32'(cfg_q) > Q_MAX) ? QC_W'(Q_MAX) : cfg_q;

  wrap_counter #(.W(D_W)) u_term (
    .clk   (clk),
    .rst   (rst),
    .clr   (term_clr),
    .inc   (term_inc),
    .last  (D_W'(d_q - DC_W'(1))),
    .count (term),
    .tc_c  (term_tc_c)
  );

  wrap_counter #(.W(Q_W)) u_neuron (
    .clk   (clk),
    .rst   (rst),
    .clr   (nrn_clr),
    .inc   (nrn_inc),
    .last  (Q_W'(q_q - QC_W'(1))),
    .count (neuron),
    .tc_c  (nrn_tc_c)
  );

  // Next state, counter controls, and strobes decoded from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    q_d      = q_q;
    w_ptr_d  = w_ptr_q;
    term_clr = 1'b0;
    term_inc = 1'b0;
    nrn_clr  = 1'b0;
    nrn_inc  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d      = cfg_d_cl;
          q_d      = cfg_q_cl;
          w_ptr_d  = '0;
          term_clr = 1'b1;
          nrn_clr  = 1'b1;
          state_d  = (cfg_d_cl == '0 || cfg_q_cl == '0) ? S_DONE : S_PRIME;
        end
      end
      S_PRIME: state_d = S_FETCH;
      S_FETCH: state_d = S_ACC;
      S_ACC: begin
        if (term_tc_c) begin
          state_d = S_RESULT;
        end else begin
          term_inc = 1'b1;
          w_ptr_d  = w_ptr_q + WA_W'(1);
          state_d  = S_FETCH;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = nrn_tc_c ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        nrn_inc  = 1'b1;
        term_clr = 1'b1;
        w_ptr_d  = w_ptr_q + WA_W'(1);
        state_d  = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_rd_d    = (state_d == S_FETCH);
    acc_en_d    = (state_d == S_ACC);
    acc_clr_d   = (state_d == S_PRIME) || (state_d == S_CLEAR);
    res_valid_d = (state_d == S_RESULT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      d_q         <= '0;
      q_q         <= '0;
      w_ptr_q     <= '0;
      mem_rd_q    <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      q_q         <= q_d;
      w_ptr_q     <= w_ptr_d;
      mem_rd_q    <= mem_rd_d;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x_addr    = term;
  assign w_addr    = w_ptr_q;
  assign res_idx   = neuron;
  assign mem_rd    = mem_rd_q;
  assign acc_en    = acc_en_q;
  assign acc_clr   = acc_clr_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: expected operand addresses and result indices
// are queued per run and retired as the DUT issues acc_en pulses and result handshakes.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] cfg_d = '0;
  logic [2:0] cfg_q = '0;
  logic       res_ready = 1'b1;
  logic [3:0] x_addr;
  logic [5:0] w_addr;
  logic       mem_rd, acc_en, acc_clr, res_valid, busy, done;
  logic [1:0] res_idx;

  int n_chk = 0;
  int n_fail = 0;
  int exp_x[$];
  int exp_w[$];
  int exp_idx[$];

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_d     (cfg_d),
    .cfg_q     (cfg_q),
    .x_addr    (x_addr),
    .w_addr    (w_addr),
    .mem_rd    (mem_rd),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One run: called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run(input int cd, input int cq, input int stall, input bit mid_start);
    int  d, q, exp_done, cyc, n_acc, n_rd, n_hs, stall_cnt, last_w, n_exp;
    bit  zero, fin;
    d = (cd > 16) ? 16 : cd;
    q = (cq > 4) ? 4 : cq;
    zero = (d == 0) || (q == 0);
    n_exp = zero ? 0 : d * q;
    exp_done = zero ? 1 : 1 + q * (2 * d + 1) + (q - 1) + 1 + q * stall;
    if (!zero) begin
      for (int n = 0; n < q; n++) begin
        for (int t = 0; t < d; t++) begin
          exp_x.push_back(t);
          exp_w.push_back(n * d + t);
        end
        exp_idx.push_back(n);
      end
    end
    n_acc = 0; n_rd = 0; n_hs = 0; stall_cnt = 0; last_w = 0; fin = 1'b0;
    cfg_d = 5'(cd);
    cfg_q = 3'(cq);
    res_ready = (stall == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 2000) begin
      if (cyc == 1) begin
        chk("busy_run", busy, 1);
        chk("prime_clr", acc_clr, !zero);
      end
      if (acc_en) begin
        n_acc++;
        if (exp_x.size() == 0) chk("acc_extra", 1, 0);
        else begin
          chk("x_addr", x_addr, exp_x.pop_front());
          chk("w_addr", w_addr, exp_w.pop_front());
        end
        last_w = w_addr;
      end
      if (mem_rd) n_rd++;
      if (res_valid) begin
        if (exp_idx.size() == 0) chk("res_extra", 1, 0);
        else chk("res_idx", res_idx, exp_idx[0]);
        if (stall_cnt < stall) begin
          res_ready = 1'b0;
          stall_cnt++;
        end else begin
          res_ready = 1'b1;
          stall_cnt = 0;
          n_hs++;
          if (exp_idx.size() > 0) void'(exp_idx.pop_front());
        end
      end else begin
        res_ready = (stall == 0);
      end
      if (mid_start && cyc == 5) begin
        start = 1'b1;
        cfg_d = 5'd1;
        cfg_q = 3'd1;
      end
      if (mid_start && cyc == 6) start = 1'b0;
      if (done) begin
        fin = 1'b1;
        chk("done_cycle", cyc, exp_done);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("acc_count", n_acc, n_exp);
    chk("rd_count", n_rd, n_exp);
    chk("hs_count", n_hs, zero ? 0 : q);
    chk("acc_left", exp_x.size(), 0);
    chk("res_left", exp_idx.size(), 0);
    if (n_exp > 0) chk("w_end", last_w, n_exp - 1);
    exp_x.delete();
    exp_w.delete();
    exp_idx.delete();
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", x_addr, 0);
    chk("rst_w", w_addr, 0);
    chk("rst_strobes", {mem_rd, acc_en, acc_clr, res_valid}, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);

    run(3, 2, 0, 1'b0);
    run(2, 1, 4, 1'b0);
    run(0, 3, 0, 1'b0);
    run(20, 1, 0, 1'b0);
    run(3, 2, 0, 1'b1);
    run(1, 4, 1, 1'b0);

    // Asynchronous reset while accumulating neuron 1 (d=4, q=2 puts that ACC in cycle 13).
    cfg_d = 5'd4;
    cfg_q = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_acc", acc_en, 1);
    chk("pre_rst_idx", res_idx, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_outs", {x_addr, w_addr, mem_rd, acc_en, acc_clr, res_valid, res_idx, busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(4, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
